// File: rtl/game_sprite_pkg.sv
// Shared types for the sprite motion controller: FSM state encoding and the
// default signed velocity type.
package game_sprite_pkg;

   localparam int unsigned STEP_W_DEF = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_FROZEN = 2'd2
   } state_t;

   typedef logic signed [STEP_W_DEF-1:0] vel_t;

endpackage

// File: rtl/game_sprite_axis_step.sv
// One-axis movement step: adds the signed velocity to the position, clamps to
// [0, LIMIT] and reflects the velocity when a wall is hit.
// Ports:
//   pos        current position (unsigned, W bits)
//   vel        current signed velocity (STEP_W bits, never the most negative value)
//   pos_next_c position after the step
//   vel_next_c velocity after the step (negated on bounce)
//   bounce_c   high when the step hit a wall
module game_sprite_axis_step #(
   parameter int unsigned W      = 10,
   parameter int unsigned STEP_W = 4,
   parameter int unsigned LIMIT  = 624
) (
   input  logic [W-1:0]             pos,
   input  logic signed [STEP_W-1:0] vel,
   output logic [W-1:0]             pos_next_c,
   output logic signed [STEP_W-1:0] vel_next_c,
   output logic                     bounce_c
);

   // two guard bits keep both the negative underflow and the overshoot visible
   localparam int unsigned        SUM_W = W + 2;
   localparam logic signed [SUM_W-1:0] LIM_S = SUM_W'(LIMIT);

   logic signed [SUM_W-1:0] sum_c;

   always_comb begin
      sum_c      = signed'({2'b00, pos}) + SUM_W'(vel);
      pos_next_c = pos;
      vel_next_c = vel;
      bounce_c   = 1'b0;
      if (sum_c < 0) begin
         pos_next_c = '0;
         vel_next_c = -vel;
         bounce_c   = 1'b1;
      end else if (sum_c > LIM_S) begin
         pos_next_c = W'(LIMIT);
         vel_next_c = -vel;
         bounce_c   = 1'b1;
      end else begin
         pos_next_c = W'(sum_c);
      end
   end

endmodule

// File: rtl/game_sprite_motion_ctrl.sv
// Sprite motion controller: IDLE/RUN/FROZEN FSM that moves a sprite by its
// velocity every FRAMES_PER_STEP frame ticks and bounces it off screen edges.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   frame_tick               one-cycle pulse per video frame
//   start/stop/freeze/resume FSM control pulses (stop has priority)
//   write_en, write_x/y/dx/dy load position (clamped) and velocity (saturated)
//   sprite_x/y, sprite_dx/dy registered position and velocity
//   moving                   high while in RUN
//   edge_x, edge_y           one-cycle bounce pulses, aligned with clamped position
module game_sprite_motion_ctrl
   import game_sprite_pkg::*;
#(
   parameter int unsigned screen_width    = 640,
   parameter int unsigned screen_height   = 480,
   parameter int unsigned w_x             = $clog2(screen_width),
   parameter int unsigned w_y             = $clog2(screen_height),
   parameter int unsigned SPRITE_WIDTH    = 16,
   parameter int unsigned SPRITE_HEIGHT   = 16,
   parameter int unsigned START_X         = 0,
   parameter int unsigned START_Y         = 0,
   parameter int unsigned STEP_W          = STEP_W_DEF,
   parameter int unsigned FRAMES_PER_STEP = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     frame_tick,
   input  logic                     start,
   input  logic                     stop,
   input  logic                     freeze,
   input  logic                     resume,
   input  logic                     write_en,
   input  logic [w_x-1:0]           write_x,
   input  logic [w_y-1:0]           write_y,
   input  logic signed [STEP_W-1:0] write_dx,
   input  logic signed [STEP_W-1:0] write_dy,
   output logic [w_x-1:0]           sprite_x,
   output logic [w_y-1:0]           sprite_y,
   output logic signed [STEP_W-1:0] sprite_dx,
   output logic signed [STEP_W-1:0] sprite_dy,
   output logic                     moving,
   output logic                     edge_x,
   output logic                     edge_y
);

   localparam int unsigned LIM_X_I = screen_width - SPRITE_WIDTH;
   localparam int unsigned LIM_Y_I = screen_height - SPRITE_HEIGHT;
   localparam logic [w_x-1:0] LIM_X = w_x'(LIM_X_I);
   localparam logic [w_y-1:0] LIM_Y = w_y'(LIM_Y_I);
   localparam logic [w_x-1:0] START_X_W = w_x'(START_X);
   localparam logic [w_y-1:0] START_Y_W = w_y'(START_Y);

   localparam int unsigned CNT_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_STEP - 1);

   localparam logic signed [STEP_W-1:0] VEL_MIN = STEP_W'(-(2 ** (STEP_W - 1)));
   localparam logic signed [STEP_W-1:0] VEL_SAT = STEP_W'(-(2 ** (STEP_W - 1) - 1));

   state_t state, state_next;
   logic [CNT_W-1:0] frame_cnt;

   logic                     run_tick_c;
   logic                     step_due_c;
   logic [w_x-1:0]           load_x_c;
   logic [w_y-1:0]           load_y_c;
   logic signed [STEP_W-1:0] load_dx_c;
   logic signed [STEP_W-1:0] load_dy_c;

   logic [w_x-1:0]           step_x_c;
   logic [w_y-1:0]           step_y_c;
   logic signed [STEP_W-1:0] step_dx_c;
   logic signed [STEP_W-1:0] step_dy_c;
   logic                     bounce_x_c;
   logic                     bounce_y_c;

   // state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // next-state logic; stop overrides every other control pulse
   always_comb begin
      state_next = state;
      if (stop) begin
         state_next = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:   if (start)  state_next = ST_RUN;
            ST_RUN:    if (freeze) state_next = ST_FROZEN;
            ST_FROZEN: if (resume) state_next = ST_RUN;
            default:   state_next = ST_IDLE;
         endcase
      end
   end

   // step scheduling and load conditioning
   always_comb begin
      run_tick_c = (state == ST_RUN) && frame_tick;
      step_due_c = run_tick_c && (frame_cnt == CNT_LAST);
      load_x_c   = (write_x > LIM_X) ? LIM_X : write_x;
      load_y_c   = (write_y > LIM_Y) ? LIM_Y : write_y;
      // the most negative velocity could not be reflected, so pull it in by one
      load_dx_c  = (write_dx == VEL_MIN) ? VEL_SAT : write_dx;
      load_dy_c  = (write_dy == VEL_MIN) ? VEL_SAT : write_dy;
   end

   game_sprite_axis_step #(
      .W      (w_x),
      .STEP_W (STEP_W),
      .LIMIT  (LIM_X_I)
   ) u_axis_x (
      .pos        (sprite_x),
      .vel        (sprite_dx),
      .pos_next_c (step_x_c),
      .vel_next_c (step_dx_c),
      .bounce_c   (bounce_x_c)
   );

   game_sprite_axis_step #(
      .W      (w_y),
      .STEP_W (STEP_W),
      .LIMIT  (LIM_Y_I)
   ) u_axis_y (
      .pos        (sprite_y),
      .vel        (sprite_dy),
      .pos_next_c (step_y_c),
      .vel_next_c (step_dy_c),
      .bounce_c   (bounce_y_c)
   );

   // position/velocity/counter datapath; priority stop > write > step
   always_ff @(posedge clk) begin
      if (rst) begin
         sprite_x  <= START_X_W;
         sprite_y  <= START_Y_W;
         sprite_dx <= '0;
         sprite_dy <= '0;
         frame_cnt <= '0;
         moving    <= 1'b0;
         edge_x    <= 1'b0;
         edge_y    <= 1'b0;
      end else begin
         edge_x <= 1'b0;
         edge_y <= 1'b0;
         moving <= (state_next == ST_RUN);

         // a write coinciding with a due step also lands the counter on 0
         if (!stop && run_tick_c) begin
            frame_cnt <= step_due_c ? '0 : frame_cnt + CNT_W'(1);
         end

         if (stop) begin
            sprite_x <= START_X_W;
            sprite_y <= START_Y_W;
         end else if (write_en) begin
            sprite_x  <= load_x_c;
            sprite_y  <= load_y_c;
            sprite_dx <= load_dx_c;
            sprite_dy <= load_dy_c;
         end else if (step_due_c) begin
            sprite_x  <= step_x_c;
            sprite_y  <= step_y_c;
            sprite_dx <= step_dx_c;
            sprite_dy <= step_dy_c;
            edge_x    <= bounce_x_c;
            edge_y    <= bounce_y_c;
         end
      end
   end

endmodule

// File: tb/tb_game_sprite_motion_ctrl.sv
// Scoreboard bench for game_sprite_motion_ctrl: a behavioural model predicts
// the outputs after every clock edge; a monitor pops and compares them.
module tb_game_sprite_motion_ctrl;

   localparam int SW  = 640;
   localparam int SH  = 480;
   localparam int SPW = 16;
   localparam int SPH = 16;
   localparam int SX  = 100;
   localparam int SY  = 200;
   localparam int FPS = 2;
   localparam int LX  = SW - SPW;
   localparam int LY  = SH - SPH;

   logic clk = 1'b0;
   logic rst, frame_tick, start, stop, freeze, resume, write_en;
   logic [9:0] write_x;
   logic [8:0] write_y;
   logic signed [3:0] write_dx, write_dy;
   logic [9:0] sprite_x;
   logic [8:0] sprite_y;
   logic signed [3:0] sprite_dx, sprite_dy;
   logic moving, edge_x, edge_y;

   game_sprite_motion_ctrl #(
      .screen_width    (SW),
      .screen_height   (SH),
      .SPRITE_WIDTH    (SPW),
      .SPRITE_HEIGHT   (SPH),
      .START_X         (SX),
      .START_Y         (SY),
      .STEP_W          (4),
      .FRAMES_PER_STEP (FPS)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .frame_tick (frame_tick),
      .start      (start),
      .stop       (stop),
      .freeze     (freeze),
      .resume     (resume),
      .write_en   (write_en),
      .write_x    (write_x),
      .write_y    (write_y),
      .write_dx   (write_dx),
      .write_dy   (write_dy),
      .sprite_x   (sprite_x),
      .sprite_y   (sprite_y),
      .sprite_dx  (sprite_dx),
      .sprite_dy  (sprite_dy),
      .moving     (moving),
      .edge_x     (edge_x),
      .edge_y     (edge_y)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic rst, tick, start, stop, freeze, resume, we;
      int   wx, wy, wdx, wdy;
   } stim_t;

   typedef struct {
      int x, y, dx, dy;
      bit mv, ex, ey;
   } exp_t;

   exp_t  exp_q[$];
   string tag_q[$];
   int    n_cmp = 0;
   int    n_err = 0;

   // model state: mode 0=idle, 1=run, 2=frozen; frames counted in run mod FPS
   int m_mode, m_x, m_y, m_dx, m_dy, m_frames;
   bit m_ex, m_ey;

   function automatic int sat_vel(input int v);
      return (v == -8) ? -7 : v;
   endfunction

   function automatic int clamp(input int v, input int lim);
      return (v > lim) ? lim : v;
   endfunction

   function automatic void move_axis(inout int p, inout int v, output bit e, input int lim);
      int n;
      n = p + v;
      e = 1'b0;
      if (n < 0) begin
         p = 0; v = -v; e = 1'b1;
      end else if (n > lim) begin
         p = lim; v = -v; e = 1'b1;
      end else begin
         p = n;
      end
   endfunction

   task automatic model_step(input stim_t s);
      bit due;
      m_ex = 1'b0;
      m_ey = 1'b0;
      if (s.rst) begin
         m_mode = 0; m_x = SX; m_y = SY; m_dx = 0; m_dy = 0; m_frames = 0;
      end else if (s.stop) begin
         m_mode = 0; m_x = SX; m_y = SY;
      end else begin
         due = (m_mode == 1) && s.tick && (m_frames == FPS - 1);
         if (m_mode == 1 && s.tick) m_frames = (m_frames + 1) % FPS;
         if (s.we) begin
            m_x  = clamp(s.wx, LX);
            m_y  = clamp(s.wy, LY);
            m_dx = sat_vel(s.wdx);
            m_dy = sat_vel(s.wdy);
         end else if (due) begin
            move_axis(m_x, m_dx, m_ex, LX);
            move_axis(m_y, m_dy, m_ey, LY);
         end
         case (m_mode)
            0: if (s.start)  m_mode = 1;
            1: if (s.freeze) m_mode = 2;
            2: if (s.resume) m_mode = 1;
            default: m_mode = 0;
         endcase
      end
   endtask

   function automatic stim_t nop();
      stim_t s;
      s.rst = 0; s.tick = 0; s.start = 0; s.stop = 0; s.freeze = 0;
      s.resume = 0; s.we = 0; s.wx = 0; s.wy = 0; s.wdx = 0; s.wdy = 0;
      return s;
   endfunction

   // drive one cycle of inputs (at negedge) and queue the predicted result
   task automatic apply(input stim_t s, input string tag);
      exp_t e;
      rst = s.rst; frame_tick = s.tick; start = s.start; stop = s.stop;
      freeze = s.freeze; resume = s.resume; write_en = s.we;
      write_x = 10'(s.wx); write_y = 9'(s.wy);
      write_dx = 4'(s.wdx); write_dy = 4'(s.wdy);
      model_step(s);
      e.x = m_x; e.y = m_y; e.dx = m_dx; e.dy = m_dy;
      e.mv = (m_mode == 1); e.ex = m_ex; e.ey = m_ey;
      exp_q.push_back(e);
      tag_q.push_back(tag);
      @(negedge clk);
   endtask

   task automatic idle(input int n, input string tag);
      for (int i = 0; i < n; i++) apply(nop(), tag);
   endtask

   task automatic tick(input string tag);
      stim_t s;
      s = nop(); s.tick = 1;
      apply(s, tag);
      apply(nop(), tag);
   endtask

   task automatic write(input int x, input int y, input int dx, input int dy, input string tag);
      stim_t s;
      s = nop(); s.we = 1; s.wx = x; s.wy = y; s.wdx = dx; s.wdy = dy;
      apply(s, tag);
   endtask

   task automatic ctrl(input int which, input string tag);
      stim_t s;
      s = nop();
      case (which)
         0: s.start = 1;
         1: s.stop = 1;
         2: s.freeze = 1;
         3: s.resume = 1;
         default: s.rst = 1;
      endcase
      apply(s, tag);
   endtask

   // monitor: compare every post-edge DUT output against the queued prediction
   initial begin
      exp_t  e;
      string t;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            n_cmp++;
            if (int'(sprite_x) != e.x || int'(sprite_y) != e.y ||
                int'(sprite_dx) != e.dx || int'(sprite_dy) != e.dy ||
                moving !== e.mv || edge_x !== e.ex || edge_y !== e.ey) begin
               n_err++;
               $display("FAIL %s @%0t: got x=%0d y=%0d dx=%0d dy=%0d mv=%b ex=%b ey=%b, want x=%0d y=%0d dx=%0d dy=%0d mv=%b ex=%b ey=%b",
                        t, $time, sprite_x, sprite_y, sprite_dx, sprite_dy, moving, edge_x, edge_y,
                        e.x, e.y, e.dx, e.dy, e.mv, e.ex, e.ey);
            end
         end
      end
   end

   initial begin
      stim_t s;
      rst = 1; frame_tick = 0; start = 0; stop = 0; freeze = 0; resume = 0;
      write_en = 0; write_x = '0; write_y = '0; write_dx = '0; write_dy = '0;
      @(negedge clk);

      ctrl(4, "reset");
      ctrl(4, "reset");
      idle(2, "reset_release");

      // steady +3 motion in x, one step per two ticks
      write(100, 200, 3, 0, "move_write");
      ctrl(0, "move_start");
      for (int i = 0; i < 4; i++) tick("move_tick");

      // right wall bounce
      ctrl(1, "stop");
      write(622, 200, 3, 0, "right_write");
      ctrl(0, "right_start");
      for (int i = 0; i < 3; i++) tick("right_tick");

      // simultaneous corner bounce at the origin
      ctrl(1, "stop");
      write(1, 1, -3, -2, "corner_write");
      ctrl(0, "corner_start");
      for (int i = 0; i < 3; i++) tick("corner_tick");

      // write collides with a due step
      ctrl(1, "stop");
      write(100, 100, 1, 1, "collide_write");
      ctrl(0, "collide_start");
      tick("collide_tick1");
      s = nop(); s.tick = 1; s.we = 1; s.wx = 50; s.wy = 100; s.wdx = 1; s.wdy = 1;
      apply(s, "collide_both");
      for (int i = 0; i < 2; i++) tick("collide_after");

      // freeze keeps position and counter; resume carries on
      tick("pre_freeze");
      ctrl(2, "freeze");
      for (int i = 0; i < 6; i++) tick("frozen_tick");
      ctrl(3, "resume");
      for (int i = 0; i < 3; i++) tick("resumed_tick");

      // stop beats write, clamps and velocity saturation
      s = nop(); s.stop = 1; s.we = 1; s.wx = 7; s.wy = 7; s.wdx = 5; s.wdy = 5;
      apply(s, "stop_vs_write");
      write(1000, 500, -8, -8, "clamp_sat");
      ctrl(0, "clamp_start");
      for (int i = 0; i < 2; i++) tick("clamp_tick");
      write(624, 464, 0, 0, "zero_vel");
      for (int i = 0; i < 2; i++) tick("zero_vel_tick");

      // reset in the middle of RUN overrides everything
      write(300, 300, 2, 2, "midrun_write");
      tick("midrun_tick");
      s = nop(); s.rst = 1; s.tick = 1; s.we = 1; s.wx = 5; s.stop = 1; s.start = 1;
      apply(s, "rst_midrun");
      idle(1, "after_rst");

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         s = nop();
         s.rst    = ($urandom_range(0, 79) == 0);
         s.tick   = ($urandom_range(0, 2) == 0);
         s.start  = ($urandom_range(0, 7) == 0);
         s.stop   = ($urandom_range(0, 23) == 0);
         s.freeze = ($urandom_range(0, 11) == 0);
         s.resume = ($urandom_range(0, 7) == 0);
         s.we     = ($urandom_range(0, 11) == 0);
         s.wx     = int'($urandom_range(0, 1023));
         s.wy     = int'($urandom_range(0, 511));
         s.wdx    = int'($urandom_range(0, 15)) - 8;
         s.wdy    = int'($urandom_range(0, 15)) - 8;
         apply(s, "random");
      end

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
      if (exp_q.size() > 0) begin
         n_err++;
         $display("FAIL drain: %0d predictions left unchecked, want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/game_sprite_motion_ctrl.md
GAME_SPRITE_MOTION_CTRL -- requirements
Module: game_sprite_motion_ctrl

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- screen_width, 640, visible width in pixels
- screen_height, 480, visible height in pixels
- w_x, $clog2(screen_width), x coordinate width
- w_y, $clog2(screen_height), y coordinate width
- SPRITE_WIDTH, 16, sprite width in pixels
- SPRITE_HEIGHT, 16, sprite height in pixels
- START_X, 0, x position after reset or stop
- START_Y, 0, y position after reset or stop
- STEP_W, 4, signed velocity width
- FRAMES_PER_STEP, 1, number of frame_tick pulses per movement step (>=1)

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  sole clock
- rst  in  1  synchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per video frame
- start  in  1  pulse; IDLE->RUN
- stop  in  1  pulse; any state->IDLE
- freeze  in  1  pulse; RUN->FROZEN
- resume  in  1  pulse; FROZEN->RUN
- write_en  in  1  load position and velocity
- write_x  in  w_x  position x to load
- write_y  in  w_y  position y to load
- write_dx  in  STEP_W  signed velocity x to load
- write_dy  in  STEP_W  signed velocity y to load
- sprite_x  out  w_x  registered position x
- sprite_y  out  w_y  registered position y
- sprite_dx  out  STEP_W  current velocity x
- sprite_dy  out  STEP_W  current velocity y
- moving  out  1  high in RUN
- edge_x  out  1  one-cycle pulse on horizontal bounce
- edge_y  out  1  one-cycle pulse on vertical bounce

Function
REQ-003 The FSM SHALL have states IDLE, RUN, FROZEN, with priority stop > start/freeze/resume; illegal inputs for the current state SHALL be ignored.
REQ-004 On entry to IDLE via stop, sprite_x, sprite_y SHALL load START_X, START_Y in the following cycle, and the velocity SHALL be retained.
REQ-005 A frame counter SHALL count frame_tick pulses only in RUN; a step SHALL be due when the counter equals FRAMES_PER_STEP-1, and the counter SHALL then wrap to 0.
REQ-006 The position SHALL update in the cycle after the frame_tick that makes a step due (latency 1); FROZEN and IDLE SHALL ignore frame_tick and hold the counter value.
REQ-007 Per axis, next = position + sign-extended velocity, computed in w+2 signed bits.
REQ-008 If next < 0 on an axis, that position SHALL be set to 0, that velocity negated, and that edge pulse raised.
REQ-009 If next > screen_dim - SPRITE_dim on an axis, that position SHALL be set to screen_dim - SPRITE_dim, that velocity negated, and that edge pulse raised.
REQ-010 The two axes SHALL be evaluated independently, and both edge pulses SHALL be able to assert in the same cycle.
REQ-011 A loaded velocity equal to -2^(STEP_W-1) SHALL saturate to -(2^(STEP_W-1)-1), so negation never overflows.
REQ-012 write_en SHALL be accepted in any state, updating position and velocity in the next cycle, and loaded positions beyond the limits of REQ-009 SHALL be clamped to those limits.
REQ-013 If write_en and a due step occur in the same cycle, the write SHALL win, the step SHALL be discarded, and the frame counter SHALL clear to 0.
REQ-014 If stop and write_en occur in the same cycle, the stop SHALL win.
REQ-015 edge_x and edge_y SHALL be registered and coincide with the cycle the clamped position appears.
REQ-016 Velocity zero on an axis SHALL produce no movement and no edge pulse on that axis.

Reset
REQ-017 rst SHALL be synchronous and active-high, and while asserted SHALL set: state=IDLE, sprite_x=START_X, sprite_y=START_Y, sprite_dx=0, sprite_dy=0, counter=0, moving=0, edge_x=0, edge_y=0.
REQ-018 rst asserted mid-RUN SHALL override all other inputs in that cycle.

Structure
REQ-019 The state enum and a signed velocity typedef SHALL reside in shared package game_sprite_pkg.
REQ-020 The per-axis add/clamp/reflect logic SHALL be one combinational sub-module, game_sprite_axis_step, instantiated twice.

Verification (screen 640x480, sprite 16x16, START 100/200, STEP_W=4, FRAMES_PER_STEP=2)
REQ-021 Release reset -> sprite_x=100, sprite_y=200, dx=dy=0, moving=0, no edge pulses.
REQ-022 write dx=+3, dy=0; start; 4 frame_ticks -> x=103 one cycle after tick 2, x=106 one cycle after tick 4; y=200.
REQ-023 write x=622, dx=+3; start; 2 ticks -> x=624, dx=-3, edge_x high exactly 1 cycle.
REQ-024 write x=1, y=1, dx=-3, dy=-2; start; 2 ticks -> x=0, y=0, dx=+3, dy=+2, edge_x and edge_y high in the same cycle.
REQ-025 In RUN with a step due, write_en with x=50 on the same cycle -> x=50, no step; the next step occurs 2 ticks later.
REQ-026 freeze then 6 ticks -> position unchanged; resume -> stepping continues from the retained counter; rst during RUN -> x=100, y=200, IDLE next cycle.
